pos_logic_pipe: RTL and testbench
=================================

Name: pos_logic_pipe

Overview:
- Parametrised successor to the team's 16-bit bitwise XOR block. Eight selectable bitwise operations over WIDTH-bit operands.
- Result and flags are registered behind a valid/ready handshake. A 2-entry skid buffer keeps IN_READY registered.
- A wrapping counter records completed output transfers.
- Sits between the MCU operand latch and the ALU result mux. Adds one pipeline stage to the logic path.

Parameters:
WIDTH, 16, operand/result width in bits (≥2)
CNT_W, 8, width of the completed-transfer counter OP_CNT (≥1)

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
CLR  input  1  synchronous clear: flush pipeline, zero counter
IN_VALID  input  1  operand/op valid
IN_READY  output  1  block can accept operands
OP  input  3  operation select
A  input  WIDTH  operand A
B  input  WIDTH  operand B
OUT_VALID  output  1  result valid
OUT_READY  input  1  downstream accepts result
OUT  output  WIDTH  result
Z  output  1  zero flag of OUT
P  output  1  odd-parity flag of OUT (XOR-reduce)
N  output  1  OUT[WIDTH-1]
OP_CNT  output  CNT_W  completed output transfers, modulo 2^CNT_W

Behaviour:
- Reset (RST_N low, asynchronous):
  - OUT_VALID=0, OUT=0, Z=0, P=0, N=0, OP_CNT=0, skid empty.
  - IN_READY=1 from the first edge after release.
- OP encoding (R is the result):
  - 000 R=A^B
  - 001 R=~(A^B)
  - 010 R=A&B
  - 011 R=A|B
  - 100 R=~(A&B)
  - 101 R=~(A|B)
  - 110 R=A&~B
  - 111 R=A (pass)
- Flags are computed from R at accept time and stored with the data: Z=(R==0), P=^R, N=R[WIDTH-1].
- Accept: IN_VALID & IN_READY at a rising edge. Emit: OUT_VALID & OUT_READY at a rising edge.
- Storage: main register (drives OUT/flags/OUT_VALID) and skid register (hidden). IN_READY = ~skid_full, registered. No combinational path from OUT_READY to IN_READY.
- Per edge (CLR low):
  - Main empty or emitted, skid empty: accepted data → main; otherwise main becomes empty.
  - Main empty or emitted, skid full: skid → main, skid empties. IN_READY was 0, so no accept.
  - Main full and not emitted, accept: data → skid (IN_READY drops next cycle).
  - Main full and not emitted, no accept: hold. OUT and flags stay stable while OUT_VALID=1 and OUT_READY=0.
- Latency: an accepted operand appears on OUT the next cycle when main is empty or emitting. Sustained throughput is 1/cycle with OUT_READY held high.
- Ordering is strict FIFO; results are never dropped or duplicated.
- OP_CNT increments by 1 on each emit and wraps from 2^CNT_W-1 to 0.
- CLR high at an edge:
  - Has priority over all other events.
  - Main and skid are emptied and OP_CNT set to 0.
  - Any accept or emit handshake in that cycle is discarded and not counted.
  - IN_READY is 1 on the following cycle.
- X on OP/A/B while IN_VALID=0 must not propagate to any output.

Test Plan:
- Reset then CLR low, WIDTH=16, OUT_READY=1; OP=000, A=16'hF0F0, B=16'hFF00, one accept -> next cycle OUT_VALID=1, OUT=16'h0FF0, Z=0, P=0, N=0; OP_CNT=1 after emit.
- Sweep all 8 OPs with A=16'hA5A5, B=16'h0FF0 -> OUT must be, in OP order:
  - 16'hAA55, 16'h55AA, 16'h05A0, 16'hAFF5
  - 16'hFA5F, 16'h500A, 16'hA005, 16'hA5A5
  - N and P must match each result.
- OP=000, A=B=16'h1234 -> OUT=0, Z=1, P=0, N=0; OP=111, A=16'h8001 -> P=0, N=1, Z=0.
- Backpressure: OUT_READY=0, issue 3 back-to-back valids -> first two accepted, IN_READY=0 from the cycle after the second; raise OUT_READY -> two results in order on consecutive cycles, then the third accepted.
- Counter wrap with CNT_W=2: 5 emits -> OP_CNT sequence 1,2,3,0,1.
- With main and skid full, assert CLR for one cycle with IN_VALID=1 -> next cycle OUT_VALID=0, OP_CNT=0, IN_READY=1, no stale result emitted; repeat with RST_N pulsed low mid-stream -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/pos_logic_pipe.sv
// Selectable bitwise logic unit with registered result/flags behind a valid/ready handshake.
// A skid register keeps in_ready registered; op_cnt counts completed output transfers.
module pos_logic_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             p,
  output logic             n,
  output logic [CNT_W-1:0] op_cnt
);

  localparam int unsigned EW = WIDTH + 3;

  logic [WIDTH-1:0] res;
  logic [EW-1:0]    in_entry;
  logic [EW-1:0]    main_q, main_d;
  logic [EW-1:0]    skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             emit;

  always_comb begin
    unique case (op)
      3'b000:  res = a ^ b;
      3'b001:  res = ~(a ^ b);
      3'b010:  res = a & b;
      3'b011:  res = a | b;
      3'b100:  res = ~(a & b);
      3'b101:  res = ~(a | b);
      3'b110:  res = a & ~b;
      default: res = a;
    endcase
  end

  // Entry layout: {n, p, z, data}; flags travel with the data they describe.
  assign in_entry = {res[WIDTH-1], ^res, (res == '0), res};

  assign accept = in_valid & in_ready_q;
  assign emit   = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    if (clr) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      cnt_d        = '0;
    end else begin
      if (emit) cnt_d = cnt_q + CNT_W'(1);
      if (!main_valid_q || emit) begin
        if (skid_valid_q) begin
          // in_ready was low, so no accept can collide with the skid drain.
          main_d       = skid_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_d       = in_entry;
          main_valid_d = 1'b1;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out       = main_q[WIDTH-1:0];
  assign z         = main_q[WIDTH];
  assign p         = main_q[WIDTH+1];
  assign n         = main_q[WIDTH+2];
  assign op_cnt    = cnt_q;

endmodule

// File: tb/tb_pos_logic_pipe.sv
// Directed bench for pos_logic_pipe: vector table plus backpressure, wrap, clear and reset sequences.
module tb_pos_logic_pipe;

  logic        clk, rst_n, clr, in_valid, out_ready;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic        in_ready, out_valid, z, p, n;
  logic [15:0] out;
  logic [7:0]  op_cnt;
  logic        in_ready2, out_valid2, z2, p2, n2;
  logic [15:0] out2;
  logic [1:0]  op_cnt2;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  pos_logic_pipe #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .z(z), .p(p), .n(n), .op_cnt(op_cnt)
  );

  pos_logic_pipe #(.WIDTH(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready), .out(out2),
    .z(z2), .p(p2), .n(n2), .op_cnt(op_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [2:0]  npz;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string name);
    check({name, " cnt8"}, 32'(op_cnt), 32'(exp_cnt % 256));
    check({name, " cnt2"}, 32'(op_cnt2), 32'(exp_cnt % 4));
  endtask

  task automatic drive(input logic [2:0] o, input logic [15:0] va, input logic [15:0] vb);
    in_valid = 1'b1;
    op = o;
    a = va;
    b = vb;
  endtask

  initial begin
    // {op, a, b, result, {n,p,z}}
    vecs[0]  = '{3'b000, 16'hA5A5, 16'h0FF0, 16'hAA55, 3'b100};
    vecs[1]  = '{3'b001, 16'hA5A5, 16'h0FF0, 16'h55AA, 3'b000};
    vecs[2]  = '{3'b010, 16'hA5A5, 16'h0FF0, 16'h05A0, 3'b000};
    vecs[3]  = '{3'b011, 16'hA5A5, 16'h0FF0, 16'hAFF5, 3'b100};
    vecs[4]  = '{3'b100, 16'hA5A5, 16'h0FF0, 16'hFA5F, 3'b100};
    vecs[5]  = '{3'b101, 16'hA5A5, 16'h0FF0, 16'h500A, 3'b000};
    vecs[6]  = '{3'b110, 16'hA5A5, 16'h0FF0, 16'hA005, 3'b100};
    vecs[7]  = '{3'b111, 16'hA5A5, 16'h0FF0, 16'hA5A5, 3'b100};
    vecs[8]  = '{3'b000, 16'h1234, 16'h1234, 16'h0000, 3'b001};
    vecs[9]  = '{3'b111, 16'h8001, 16'h0000, 16'h8001, 3'b100};
    vecs[10] = '{3'b111, 16'h0001, 16'hFFFF, 16'h0001, 3'b010};
    vecs[11] = '{3'b010, 16'hFFFF, 16'h0007, 16'h0007, 3'b010};
    vecs[12] = '{3'b011, 16'h8000, 16'h0000, 16'h8000, 3'b110};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'b0; a = '0; b = '0;
    #3;
    check("reset out_valid", 32'(out_valid), 32'(0));
    check("reset out", 32'(out), 32'(0));
    check("reset flags", 32'({n, p, z}), 32'(0));
    check("reset cnt", 32'(op_cnt), 32'(0));
    #9 rst_n = 1'b1;
    step();
    check("in_ready after reset", 32'(in_ready), 32'(1));

    // Single transaction
    drive(3'b000, 16'hF0F0, 16'hFF00);
    step();
    in_valid = 1'b0;
    check("first out_valid", 32'(out_valid), 32'(1));
    check("first out", 32'(out), 32'(16'h0FF0));
    check("first flags", 32'({n, p, z}), 32'(0));
    step();
    exp_cnt++;
    check("first emitted", 32'(out_valid), 32'(0));
    check_cnt("first");

    // Back-to-back table, one result per cycle
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      step();
      check($sformatf("vec%0d valid", i), 32'(out_valid), 32'(1));
      check($sformatf("vec%0d out", i), 32'(out), 32'(vecs[i].r));
      check($sformatf("vec%0d npz", i), 32'({n, p, z}), 32'(vecs[i].npz));
    end
    in_valid = 1'b0;
    op = 'x; a = 'x; b = 'x;
    step();
    exp_cnt += 13;
    check_cnt("table");
    step();
    check("idle with x inputs valid", 32'(out_valid), 32'(0));

    // Backpressure: two accepted, third stalls until drain
    out_ready = 1'b0;
    drive(3'b111, 16'h1111, 16'h0);
    step();
    check("bp v0 out", 32'(out), 32'(16'h1111));
    check("bp rdy after 1st", 32'(in_ready), 32'(1));
    drive(3'b111, 16'h2222, 16'h0);
    step();
    check("bp rdy after 2nd", 32'(in_ready), 32'(0));
    drive(3'b111, 16'h3333, 16'h0);
    step();
    check("bp hold out", 32'(out), 32'(16'h1111));
    check("bp hold rdy", 32'(in_ready), 32'(0));
    out_ready = 1'b1;
    step();
    check("bp drain v1", 32'(out), 32'(16'h2222));
    check("bp drain rdy", 32'(in_ready), 32'(1));
    step();
    in_valid = 1'b0;
    check("bp v2 valid", 32'(out_valid), 32'(1));
    check("bp v2 out", 32'(out), 32'(16'h3333));
    step();
    exp_cnt += 3;
    check("bp done valid", 32'(out_valid), 32'(0));
    check_cnt("bp");

    // Counter wrap on the 2-bit instance
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_cnt = 0;
    check_cnt("clr zero");
    for (int k = 0; k < 5; k++) begin
      drive(3'b010, 16'h00FF, 16'h0F0F);
      step();
      in_valid = 1'b0;
      step();
      exp_cnt++;
      check_cnt($sformatf("wrap%0d", k));
    end

    // CLR with main and skid full, handshakes present
    out_ready = 1'b0;
    drive(3'b111, 16'hAAAA, 16'h0);
    step();
    drive(3'b111, 16'hBBBB, 16'h0);
    step();
    check("pre-clr full", 32'(in_ready), 32'(0));
    clr = 1'b1;
    out_ready = 1'b1;
    step();
    clr = 1'b0;
    in_valid = 1'b0;
    exp_cnt = 0;
    check("clr out_valid", 32'(out_valid), 32'(0));
    check("clr in_ready", 32'(in_ready), 32'(1));
    check_cnt("clr");
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("clr no stale %0d", k), 32'(out_valid), 32'(0));
    end
    check_cnt("clr after");

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(3'b111, 16'h8000, 16'h0);
    step();
    drive(3'b111, 16'hC000, 16'h0);
    step();
    in_valid = 1'b0;
    check("pre-rst out", 32'(out), 32'(16'h8000));
    #2 rst_n = 1'b0;
    #1;
    check("rst out_valid", 32'(out_valid), 32'(0));
    check("rst out", 32'(out), 32'(0));
    check("rst flags", 32'({n, p, z}), 32'(0));
    check("rst in_ready", 32'(in_ready), 32'(0));
    check("rst cnt", 32'(op_cnt), 32'(0));
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("post-rst in_ready", 32'(in_ready), 32'(1));
    check("post-rst no stale", 32'(out_valid), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
